pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_seq_state_t;

  // Consecutive low lock_s cycles needed in RUN before a loss is believed (filter build only).
  localparam int LOSS_FILTER_CYCLES = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer with bounded retries.
// Define PLL_SEQ_GLITCH_FILTER_EN to ignore lock dips in RUN shorter than LOSS_FILTER_CYCLES.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk25_i,
  input  logic       rst_n_i,
  input  logic       locked_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       error_o,
  output logic [7:0] relock_cnt_o
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic             lock_s;
  pll_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       relock_d;
  logic             loss_trip;

  sync_2ff u_lock_sync (
    .clk   (clk25_i),
    .rst_n (rst_n_i),
    .d     (locked_i),
    .q     (lock_s)
  );

`ifdef PLL_SEQ_GLITCH_FILTER_EN
  localparam int LOSS_W = $clog2(LOSS_FILTER_CYCLES + 1);
  logic [LOSS_W-1:0] loss_q, loss_d;

  assign loss_trip = !lock_s && (loss_q == LOSS_W'(LOSS_FILTER_CYCLES - 1));

  always_ff @(posedge clk25_i or negedge rst_n_i) begin
    if (!rst_n_i) loss_q <= '0;
    else          loss_q <= loss_d;
  end
`else
  assign loss_trip = !lock_s;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = relock_cnt_o;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
    loss_d   = '0;
`endif
    case (state_q)
      ST_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_d = '0;
          if (retry_q == RTY_W'(MAX_RETRIES)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RST;
            retry_d = retry_q + RTY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (loss_trip) begin
          state_d = ST_RST;
          cnt_d   = '0;
          if (relock_cnt_o != 8'hFF) relock_d = relock_cnt_o + 8'd1;
        end
`ifdef PLL_SEQ_GLITCH_FILTER_EN
        else if (!lock_s) begin
          loss_d = loss_q + LOSS_W'(1);
        end
`endif
      end
      ST_FAIL: ;
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk25_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      relock_cnt_o <= 8'd0;
      pll_rst_o    <= 1'b1;
      sys_rst_n_o  <= 1'b0;
      ready_o      <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      relock_cnt_o <= relock_d;
      pll_rst_o    <= (state_d == ST_RST) || (state_d == ST_FAIL);
      sys_rst_n_o  <= (state_d == ST_RUN);
      ready_o      <= (state_d == ST_RUN);
      error_o      <= (state_d == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench: power-up, lock dip, timeout/fail, stable drop, mid-run resets, relock saturation.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       rst_n, locked;
  logic       pll_rst, sys_rst_n, ready, error;
  logic [7:0] relock;
  logic       s_rst_n, s_locked;
  logic       s_pll_rst, s_sys_rst_n, s_ready, s_error;
  logic [7:0] s_relock;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(16), .STABLE_CYCLES(1024), .TIMEOUT_CYCLES(100), .MAX_RETRIES(3)
  ) u_dut (
    .clk25_i(clk), .rst_n_i(rst_n), .locked_i(locked),
    .pll_rst_o(pll_rst), .sys_rst_n_o(sys_rst_n), .ready_o(ready),
    .error_o(error), .relock_cnt_o(relock)
  );

  pll_lock_sequencer #(
    .RST_CYCLES(2), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(50), .MAX_RETRIES(3)
  ) u_sat (
    .clk25_i(clk), .rst_n_i(s_rst_n), .locked_i(s_locked),
    .pll_rst_o(s_pll_rst), .sys_rst_n_o(s_sys_rst_n), .ready_o(s_ready),
    .error_o(s_error), .relock_cnt_o(s_relock)
  );

  always #5 clk = ~clk;

  // Index 0 is the current negedge; returns -1 if ready never rises within limit.
  task automatic wait_ready(input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      if (ready) begin
        idx = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    locked = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (pll_rst !== 1'b1)   begin n_err++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
    n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
    n_cmp++; if (error !== 1'b0)     begin n_err++; $display("FAIL reset_error got %b want 0", error); end
    n_cmp++; if (relock !== 8'd0)    begin n_err++; $display("FAIL reset_relock got %0d want 0", relock); end
  endtask

  task automatic test_power_up();
    int hi, rdy, err_seen;
    hi = 0; rdy = -1; err_seen = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (i < 40 && pll_rst) hi++;
      if (error) err_seen = 1;
      if (ready && rdy < 0) rdy = i;
      if (rdy >= 0) break;
      @(negedge clk);
    end
    n_cmp++; if (hi != 16) begin n_err++; $display("FAIL pwr_pll_rst_len got %0d want 16", hi); end
    n_cmp++; if (rdy < 1041 || rdy > 1043) begin n_err++; $display("FAIL pwr_ready_cycle got %0d want 1041..1043", rdy); end
    n_cmp++; if (err_seen != 0) begin n_err++; $display("FAIL pwr_error got %0d want 0", err_seen); end
    n_cmp++; if (sys_rst_n !== 1'b1) begin n_err++; $display("FAIL pwr_sys_rst_n got %b want 1", sys_rst_n); end
  endtask

  task automatic test_glitch();
    int seen_low, idx;
    seen_low = 0;
    @(negedge clk) locked = 1'b0;
    @(negedge clk) locked = 1'b1;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
    for (int i = 0; i < 10; i++) begin
      if (!sys_rst_n || !ready) seen_low = 1;
      @(negedge clk);
    end
    n_cmp++; if (seen_low != 0) begin n_err++; $display("FAIL glitch_ignored got %0d want 0", seen_low); end
    n_cmp++; if (relock !== 8'd0) begin n_err++; $display("FAIL glitch_relock got %0d want 0", relock); end
`else
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (!sys_rst_n) seen_low = 1;
    end
    n_cmp++; if (seen_low != 1) begin n_err++; $display("FAIL glitch_sys_rst got %0d want 1", seen_low); end
    n_cmp++; if (relock !== 8'd1) begin n_err++; $display("FAIL glitch_relock got %0d want 1", relock); end
    wait_ready(1200, idx);
    n_cmp++; if (idx < 0) begin n_err++; $display("FAIL glitch_relock_ready got %0d want >=0", idx); end
`endif
  endtask

  task automatic test_reset_in_run();
    int idx;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL run_pre_ready got %b want 1", ready); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (pll_rst !== 1'b1)   begin n_err++; $display("FAIL runrst_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_rst_n !== 1'b0) begin n_err++; $display("FAIL runrst_sys_rst_n got %b want 0", sys_rst_n); end
    n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL runrst_ready got %b want 0", ready); end
    n_cmp++; if (relock !== 8'd0)    begin n_err++; $display("FAIL runrst_relock got %0d want 0", relock); end
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    wait_ready(1200, idx);
    n_cmp++; if (idx < 1041 || idx > 1043) begin n_err++; $display("FAIL runrst_restart got %0d want 1041..1043", idx); end
  endtask

  task automatic test_stable_drop();
    int rdy;
    rdy = -1;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      if (ready && rdy < 0) rdy = i;
      if (rdy >= 0) break;
      // STABLE count is 500 when this dip reaches lock_s.
      if (i == 515) locked = 1'b0;
      if (i == 516) locked = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (rdy < 1542 || rdy > 1544) begin n_err++; $display("FAIL stable_drop_ready got %0d want 1542..1544", rdy); end
    n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL stable_drop_error got %b want 0", error); end
  endtask

  task automatic test_timeout();
    int falls, err_idx;
    logic prev;
    falls = 0; err_idx = -1;
    locked = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    prev = pll_rst;
    for (int i = 0; i < 700; i++) begin
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
      if (error && err_idx < 0) err_idx = i;
      @(negedge clk);
    end
    n_cmp++; if (falls != 4) begin n_err++; $display("FAIL timeout_pulses got %0d want 4", falls); end
    n_cmp++; if (err_idx != 464) begin n_err++; $display("FAIL timeout_error_cycle got %0d want 464", err_idx); end
    n_cmp++; if (pll_rst !== 1'b1)   begin n_err++; $display("FAIL fail_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_rst_n !== 1'b0) begin n_err++; $display("FAIL fail_sys_rst_n got %b want 0", sys_rst_n); end
    n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL fail_ready got %b want 0", ready); end
    locked = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL fail_held got %b want 1", error); end
  endtask

  task automatic test_reset_in_fail();
    int idx;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (error !== 1'b0)   begin n_err++; $display("FAIL failrst_error got %b want 0", error); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL failrst_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (ready !== 1'b0)   begin n_err++; $display("FAIL failrst_ready got %b want 0", ready); end
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    wait_ready(1200, idx);
    n_cmp++; if (idx < 1041 || idx > 1043) begin n_err++; $display("FAIL failrst_restart got %0d want 1041..1043", idx); end
  endtask

  task automatic test_saturate();
    int misses;
    misses = 0;
    @(negedge clk) s_rst_n = 1'b1;
    for (int k = 0; k <= 300; k++) begin
      // k == 0 is the initial bring-up; each later pass is one lock loss in RUN.
      if (k > 0) begin
        @(negedge clk) s_locked = 1'b0;
        repeat (8) @(negedge clk);
        s_locked = 1'b1;
      end
      for (int i = 0; i < 100; i++) begin
        if (s_ready) break;
        @(negedge clk);
        if (i == 99) misses++;
      end
      if (k == 200) begin
        n_cmp++; if (s_relock !== 8'd200) begin n_err++; $display("FAIL sat_relock_200 got %0d want 200", s_relock); end
      end
      if (k == 255) begin
        n_cmp++; if (s_relock !== 8'd255) begin n_err++; $display("FAIL sat_relock_255 got %0d want 255", s_relock); end
      end
    end
    n_cmp++; if (s_relock !== 8'd255) begin n_err++; $display("FAIL sat_relock_final got %0d want 255", s_relock); end
    n_cmp++; if (misses != 0) begin n_err++; $display("FAIL sat_relock_timeouts got %0d want 0", misses); end
    n_cmp++; if (s_error !== 1'b0 || s_ready !== 1'b1) begin n_err++; $display("FAIL sat_state got err=%b rdy=%b want 0/1", s_error, s_ready); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; locked = 1'b1;
    s_rst_n = 1'b0; s_locked = 1'b1;
    @(negedge clk);
    test_reset();
    test_power_up();
    test_glitch();
    test_reset_in_run();
    test_stable_drop();
    test_timeout();
    test_reset_in_fail();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
